exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter DATA_W, default 8: operand/result width.
REQ-002 Parameter ADDR_W, default 8: register address width.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  unit can accept an instruction.
REQ-007 instr_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MUL, 7 MOV.
REQ-008 instr_rd / instr_rs1 / instr_rs2  in  ADDR_W each  destination / source registers.
REQ-009 r1_addr / r2_addr  out  ADDR_W each  register-file read addresses.
REQ-010 r1_data / r2_data  in  DATA_W each  register-file read data (combinational read).
REQ-011 write  out  1  register-file write enable.
REQ-012 write_addr  out  ADDR_W  write-back address.
REQ-013 write_data  out  DATA_W  write-back data.
REQ-014 done  out  1  one-cycle pulse coincident with write.
REQ-015 flag_zero / flag_carry  out  1 each  status of last completed instruction.

Function
REQ-016 FSM states IDLE, READ, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on instr_valid & instr_ready at an edge, latch op/rd/rs1/rs2 and go to READ; otherwise stay.
REQ-018 READ (1 cycle): r1_addr=rs1, r2_addr=rs2 from latched fields; capture r1_data/r2_data into operand registers at the closing edge; go to EXEC.
REQ-019 r1_addr/r2_addr SHALL hold the latched rs1/rs2 in all non-IDLE states; 0 after reset until first accept.
REQ-020 EXEC, non-MUL ops: result computed in one cycle (ADD a+b, SUB a-b, AND/OR/XOR bitwise, SHL a<<b[2:0], MOV a); go to WB.
REQ-021 EXEC, MUL: shift-add over exactly 8 cycles, 3-bit counter 0..7; result = low DATA_W bits of a*b; go to WB after count 7.
REQ-022 WB (1 cycle): write=1, done=1, write_addr=rd, write_data=result; go to IDLE.
REQ-023 write/done SHALL be 0 in every state other than WB.
REQ-024 Latency: accept at edge t0 -> write high in cycle t2..t3 (non-MUL), t10..t11 (MUL); next accept no earlier than edge t4 (non-MUL).
REQ-025 flag_carry: ADD carry-out; SUB borrow (a<b); MUL 1 if high product bits nonzero; 0 for all other ops.
REQ-026 flag_zero = (result == 0); both flags update at the edge leaving WB and hold until the next WB.
REQ-027 RAW hazards: register write lands at the edge ending WB, before any later READ, so a dependent next instruction SHALL read the new value without stalling.
REQ-028 rd == rs1 or rs2 is legal; operands are the pre-write values.
REQ-029 instr_valid while not ready is ignored; instruction fields sampled only at the accept edge.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, write=0, done=0, instr_ready=0, all address/data outputs 0, flags 0, MUL counter 0.
REQ-031 instr_ready SHALL rise in the first cycle after reset_n deasserts.
REQ-032 Reset mid-instruction discards it; no write SHALL be issued for it.

Structure
REQ-033 Package exec_pkg holds DATA_W/ADDR_W defaults, opcode constants, FSM state encoding.
REQ-034 Iterative multiplier SHALL be sub-module seq_mul (start, a, b -> busy, product, overflow).

Verification
REQ-035 Bench pairs exec_unit with a behavioural 256x8 register model, preloaded per test.
REQ-036 Reset: reset_n=0 -> write=0, instr_ready=0, flags 0; release -> instr_ready=1 next cycle.
REQ-037 ADD rd=12 rs1=10(0x55) rs2=11(0xB0) -> write 3rd cycle after accept, addr 12, data 0x05, carry=1, zero=0.
REQ-038 SUB rd=3 rs1=1(0x10) rs2=2(0x10) -> data 0x00, zero=1, carry=0.
REQ-039 MUL 0x0F*0x11 -> 0xFF, carry=0, write 11 cycles after accept; MUL 0x20*0x10 -> 0x00, carry=1, zero=1.
REQ-040 Back-to-back: ADD rd=5 (0x01+0x02), then MOV rd=6 rs1=5 -> reg6 = 0x03.
REQ-041 MUL accepted, reset_n low 5 cycles later -> write never asserts, unit returns to IDLE, destination unchanged.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execution unit: default widths, opcodes and FSM states.
package exec_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_MUL = 3'd6,
    OP_MOV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage

// File: rtl/exec_unit_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle for exactly eight cycles.
// The eight-step schedule covers an 8-bit multiplier; wider DATA_W only sees its low 8 bits of b.
module seq_mul
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] product,
  output logic              overflow
);

  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [2:0]          count_q;

  // start loads the operands; busy drops on the edge that completes step 7
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= 3'd0;
      busy     <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{DATA_W{1'b0}}, a};
      mplier_q <= b;
      count_q  <= 3'd0;
      busy     <= 1'b1;
    end else if (busy) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 3'd1;
      if (count_q == 3'd7) begin
        busy <= 1'b0;
      end
    end
  end

  assign product  = acc_q[DATA_W-1:0];
  assign overflow = |acc_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: accept, read registers, execute (ALU or iterative MUL), write back.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  output logic [ADDR_W-1:0] r1_addr,
  output logic [ADDR_W-1:0] r2_addr,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [DATA_W-1:0] r2_data,
  output logic              write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              flag_zero,
  output logic              flag_carry
);

  state_e            state_q, state_d;
  logic              out_of_reset_q;
  op_e               op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] opnd_a_q, opnd_b_q, result_q;
  logic              carry_q;

  logic              accept;
  logic              mul_start, mul_busy, mul_ovf;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [DATA_W:0]   sum;

  // ready is held low until the first edge after reset so a just-released unit takes nothing
  assign instr_ready = out_of_reset_q && (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign mul_start   = (state_q == READ) && (op_q == OP_MUL);

  assign r1_addr    = rs1_q;
  assign r2_addr    = rs2_q;
  assign write      = (state_q == WB);
  assign done       = (state_q == WB);
  assign write_addr = rd_q;
  assign write_data = result_q;

  // The multiplier loads straight from the register-file read port so its eight
  // steps fit between the READ edge and the WB edge.
  seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (mul_start),
    .a        (r1_data),
    .b        (r2_data),
    .busy     (mul_busy),
    .product  (mul_product),
    .overflow (mul_ovf)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      out_of_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_of_reset_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    if (op_q != OP_MUL || !mul_busy) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    sum        = '0;
    case (op_q)
      OP_ADD: begin
        sum        = {1'b0, opnd_a_q} + {1'b0, opnd_b_q};
        alu_result = sum[DATA_W-1:0];
        alu_carry  = sum[DATA_W];
      end
      OP_SUB: begin
        alu_result = opnd_a_q - opnd_b_q;
        alu_carry  = (opnd_a_q < opnd_b_q);
      end
      OP_AND: alu_result = opnd_a_q & opnd_b_q;
      OP_OR:  alu_result = opnd_a_q | opnd_b_q;
      OP_XOR: alu_result = opnd_a_q ^ opnd_b_q;
      OP_SHL: alu_result = opnd_a_q << opnd_b_q[2:0];
      OP_MUL: begin
        alu_result = mul_product;
        alu_carry  = mul_ovf;
      end
      OP_MOV: alu_result = opnd_a_q;
      default: ;
    endcase
  end

  // Flags come from the result register so they change only on the edge leaving WB
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_ADD;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      opnd_a_q   <= '0;
      opnd_b_q   <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= op_e'(instr_op);
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
      end
      if (state_q == READ) begin
        opnd_a_q <= r1_data;
        opnd_b_q <= r2_data;
      end
      if (state_q == EXEC && state_d == WB) begin
        result_q <= alu_result;
        carry_q  <= alu_carry;
      end
      if (state_q == WB) begin
        flag_zero  <= (result_q == '0);
        flag_carry <= carry_q;
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural 256x8 register file model.
module tb_exec_unit;
  import exec_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [7:0] instr_rd, instr_rs1, instr_rs2;
  logic [7:0] r1_addr, r2_addr;
  logic [7:0] r1_data, r2_data;
  logic       write;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic       done;
  logic       flag_zero, flag_carry;

  logic [7:0] regs [0:255];
  int         write_count;
  int         errors;
  int         checks;

  exec_unit #(.DATA_W(8), .ADDR_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .r1_addr     (r1_addr),
    .r2_addr     (r2_addr),
    .r1_data     (r1_data),
    .r2_data     (r2_data),
    .write       (write),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .done        (done),
    .flag_zero   (flag_zero),
    .flag_carry  (flag_carry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: combinational read, write on the rising edge
  assign r1_data = regs[r1_addr];
  assign r2_data = regs[r2_addr];

  always @(posedge clock) begin
    if (write === 1'b1) begin
      regs[write_addr] = write_data;
      write_count = write_count + 1;
    end
  end

  // Offer one instruction at a negedge, scramble the fields after the accept edge,
  // then count negedges until write is seen (1 = the cycle right after accept).
  task automatic issue(input logic [2:0] op, input logic [7:0] rd,
                       input logic [7:0] rs1, input logic [7:0] rs2, output int lat);
    int guard;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    instr_op    = 3'd7;
    instr_rd    = 8'hEE;
    instr_rs1   = 8'hEF;
    instr_rs2   = 8'hED;
    lat = 1;
    while (write !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b expected 0", write); end
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", instr_ready); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {flag_zero, flag_carry}); end
    checks++; if (r1_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_r1_addr: got %h expected 00", r1_addr); end
    reset_n = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_at_release: got %b expected 0", instr_ready); end
    @(negedge clock);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_release: got %b expected 1", instr_ready); end
  endtask

  task automatic test_add();
    int lat;
    regs[10] = 8'h55; regs[11] = 8'hB0; regs[12] = 8'h00;
    issue(OP_ADD, 8'd12, 8'd10, 8'd11, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL add_latency: got %0d expected 3", lat); end
    checks++; if (write_addr !== 8'd12) begin errors++; $display("[TB] FAIL add_addr: got %h expected 0c", write_addr); end
    checks++; if (write_data !== 8'h05) begin errors++; $display("[TB] FAIL add_data: got %h expected 05", write_data); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL add_done: got %b expected 1", done); end
    @(negedge clock);
    checks++; if (flag_carry !== 1'b1) begin errors++; $display("[TB] FAIL add_carry: got %b expected 1", flag_carry); end
    checks++; if (flag_zero !== 1'b0) begin errors++; $display("[TB] FAIL add_zero: got %b expected 0", flag_zero); end
    checks++; if ({write, done} !== 2'b00) begin errors++; $display("[TB] FAIL add_write_drop: got %b expected 00", {write, done}); end
    checks++; if (regs[12] !== 8'h05) begin errors++; $display("[TB] FAIL add_reg12: got %h expected 05", regs[12]); end
  endtask

  task automatic test_sub();
    int lat;
    regs[1] = 8'h10; regs[2] = 8'h10; regs[3] = 8'hFF;
    issue(OP_SUB, 8'd3, 8'd1, 8'd2, lat);
    checks++; if (write_data !== 8'h00) begin errors++; $display("[TB] FAIL sub_data: got %h expected 00", write_data); end
    @(negedge clock);
    checks++; if (flag_zero !== 1'b1) begin errors++; $display("[TB] FAIL sub_zero: got %b expected 1", flag_zero); end
    checks++; if (flag_carry !== 1'b0) begin errors++; $display("[TB] FAIL sub_carry: got %b expected 0", flag_carry); end
  endtask

  // Remaining ALU ops, a borrowing SUB, and a write to its own source register
  task automatic test_logic();
    int         lat;
    logic [2:0] t_op   [7];
    logic [7:0] t_rs1  [7];
    logic [7:0] t_rd   [7];
    logic [7:0] t_data [7];
    logic       t_cy   [7];
    t_op   = '{OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SUB, OP_MOV, OP_ADD};
    t_rs1  = '{8'd30, 8'd30, 8'd30, 8'd30, 8'd32, 8'd31, 8'd30};
    t_rd   = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd30};
    t_data = '{8'h42, 8'hDB, 8'h99, 8'h0C, 8'hF0, 8'h5A, 8'h1D};
    t_cy   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    regs[30] = 8'hC3; regs[31] = 8'h5A; regs[32] = 8'h10; regs[33] = 8'h20;
    for (int i = 0; i < 7; i++) begin
      issue(t_op[i], t_rd[i], t_rs1[i], t_rs1[i] + 8'd1, lat);
      checks++; if (write_data !== t_data[i]) begin errors++; $display("[TB] FAIL logic%0d_data: got %h expected %h", i, write_data, t_data[i]); end
      checks++; if (write_addr !== t_rd[i]) begin errors++; $display("[TB] FAIL logic%0d_addr: got %h expected %h", i, write_addr, t_rd[i]); end
      @(negedge clock);
      checks++; if (flag_carry !== t_cy[i]) begin errors++; $display("[TB] FAIL logic%0d_carry: got %b expected %b", i, flag_carry, t_cy[i]); end
      checks++; if (flag_zero !== 1'b0) begin errors++; $display("[TB] FAIL logic%0d_zero: got %b expected 0", i, flag_zero); end
    end
    checks++; if (regs[30] !== 8'h1D) begin errors++; $display("[TB] FAIL self_write_reg30: got %h expected 1d", regs[30]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    regs[50] = 8'h01; regs[51] = 8'h02; regs[5] = 8'h00; regs[6] = 8'h00;
    issue(OP_ADD, 8'd5, 8'd50, 8'd51, lat);
    checks++; if (write_data !== 8'h03) begin errors++; $display("[TB] FAIL b2b_add_data: got %h expected 03", write_data); end
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_in_wb: got %b expected 0", instr_ready); end
    @(negedge clock);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_wb: got %b expected 1", instr_ready); end
    issue(OP_MOV, 8'd6, 8'd5, 8'd0, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL b2b_mov_latency: got %0d expected 3", lat); end
    @(negedge clock);
    checks++; if (regs[6] !== 8'h03) begin errors++; $display("[TB] FAIL b2b_reg6: got %h expected 03", regs[6]); end
  endtask

  task automatic test_mul();
    int lat;
    regs[20] = 8'h0F; regs[21] = 8'h11; regs[22] = 8'h00;
    issue(OP_MUL, 8'd22, 8'd20, 8'd21, lat);
    checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL mul1_latency: got %0d expected 11", lat); end
    checks++; if (write_data !== 8'hFF) begin errors++; $display("[TB] FAIL mul1_data: got %h expected ff", write_data); end
    @(negedge clock);
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("[TB] FAIL mul1_flags: got %b expected 00", {flag_zero, flag_carry}); end
    regs[23] = 8'h20; regs[24] = 8'h10; regs[25] = 8'hAA;
    issue(OP_MUL, 8'd25, 8'd23, 8'd24, lat);
    checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL mul2_latency: got %0d expected 11", lat); end
    checks++; if (write_data !== 8'h00) begin errors++; $display("[TB] FAIL mul2_data: got %h expected 00", write_data); end
    @(negedge clock);
    checks++; if ({flag_zero, flag_carry} !== 2'b11) begin errors++; $display("[TB] FAIL mul2_flags: got %b expected 11", {flag_zero, flag_carry}); end
    checks++; if (regs[25] !== 8'h00) begin errors++; $display("[TB] FAIL mul2_reg25: got %h expected 00", regs[25]); end
  endtask

  // A MUL cut off by reset must never write its destination
  task automatic test_reset_mid_mul();
    int writes_before;
    int guard;
    regs[60] = 8'h03; regs[61] = 8'h04; regs[62] = 8'hAA;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    writes_before = write_count;
    instr_valid = 1'b1; instr_op = OP_MUL; instr_rd = 8'd62; instr_rs1 = 8'd60; instr_rs2 = 8'd61;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++; if ({write, done, instr_ready} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_outputs: got %b expected 000", {write, done, instr_ready}); end
    checks++; if (r1_addr !== 8'h00) begin errors++; $display("[TB] FAIL midrst_r1_addr: got %h expected 00", r1_addr); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_flags: got %b expected 00", {flag_zero, flag_carry}); end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    checks++; if (write_count !== writes_before) begin errors++; $display("[TB] FAIL midrst_writes: got %0d expected %0d", write_count, writes_before); end
    checks++; if (regs[62] !== 8'hAA) begin errors++; $display("[TB] FAIL midrst_reg62: got %h expected aa", regs[62]); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle: got %b expected 1", instr_ready); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    write_count = 0;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 3'd0;
    instr_rd    = 8'h00;
    instr_rs1   = 8'h00;
    instr_rs2   = 8'h00;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
